// File: rtl/feature_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : feature_ram_arbiter
//  Purpose  : Burst-based round-robin arbiter that shares the single-port
//             feature/weight RAM between NUM_REQ requesters (host loader,
//             conv-window fetch, result writeback). The RAM port is driven
//             from registers, and read data is steered back to the requester
//             that issued the read, even after the grant has moved on.
//  Ports    : clk, rst             - clock, asynchronous active-high reset
//             req/we/last          - per-requester beat offer, write flag,
//                                    final-beat flag
//             addr/wdata           - flattened per-requester beat fields,
//                                    requester i at [i*W +: W]
//             gnt                  - registered one-hot grant (or zero)
//             ram_en/ram_we/ram_addr/ram_wdata - registered RAM port
//             ram_rdata            - RAM read data (one cycle after ram_en)
//             rd_valid/rd_data     - one-hot read return strobe and data
//             busy                 - granted, or a read still in flight
//  Revision : 1.0 - initial release
// ============================================================================
module feature_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0]             last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           ram_en,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_IDX_W-1:0]     r_owner, w_owner_nxt;
    logic [c_IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt;

    logic                   r_ram_en, r_ram_we;
    logic [ADDR_WIDTH-1:0]  r_ram_addr;
    logic [DATA_WIDTH-1:0]  r_ram_wdata;
    logic                   r_rd_pend;
    logic [c_IDX_W-1:0]     r_rd_tag;
    logic [NUM_REQ-1:0]     r_rd_valid, w_rd_valid_nxt;

    // Beat fields of the current owner
    logic                   w_sel_req, w_sel_we, w_sel_last;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    // Round-robin search
    logic [c_IDX_W-1:0]     w_owner_inc, w_arb_start, w_pick;
    logic [NUM_REQ-1:0]     w_rot;
    logic [c_IDX_W:0]       w_sum;
    logic                   w_found;

    logic                   w_beat, w_release;

    always_comb begin
        w_sel_req   = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == c_IDX_W'(i)) begin
                w_sel_req   = req[i];
                w_sel_we    = we[i];
                w_sel_last  = last[i];
                w_sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_owner_inc = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

    // On a release the search starts just past the outgoing owner, which is
    // where the pointer is about to move; in IDLE it starts at the pointer.
    assign w_arb_start = (r_state == ST_GRANT) ? w_owner_inc : r_ptr;

    // Rotate the request vector so bit 0 is the search start; the first set
    // bit is then the winner, translated back by adding the start modulo N.
    assign w_rot = NUM_REQ'({req, req} >> w_arb_start);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, w_arb_start} + (c_IDX_W+1)'(k);
                if (w_sum >= (c_IDX_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (c_IDX_W+1)'(NUM_REQ);
                end
                w_pick  = w_sum[c_IDX_W-1:0];
            end
        end
    end

    // Next-state / grant logic
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = r_cnt + 1'b1;
        w_beat      = (r_state == ST_GRANT) && w_sel_req;
        // A dropped request releases without a beat; otherwise release on the
        // last beat or on the beat that fills the burst allowance.
        w_release   = (r_state == ST_GRANT) &&
                      (!w_sel_req || w_sel_last || (w_cnt_inc == c_MAX_CNT));

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_beat) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                if (w_release) begin
                    w_ptr_nxt = w_owner_inc;
                    w_cnt_nxt = '0;
                    if (w_found) begin
                        w_owner_nxt = w_pick;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_gnt_nxt      = '0;
        w_rd_valid_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_nxt[i]      = (w_state_nxt == ST_GRANT) && (w_owner_nxt == c_IDX_W'(i));
            w_rd_valid_nxt[i] = r_rd_pend && (r_rd_tag == c_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_tag    <= '0;
            r_rd_valid  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ram_en   <= w_beat;
            r_ram_we   <= w_beat && w_sel_we;
            // Address/data hold between beats so the RAM port stays quiet
            if (w_beat) begin
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
                r_rd_tag    <= r_owner;
            end
            // The tag travels alongside ram_en, so it is unaffected by a
            // grant change on the following edge.
            r_rd_pend  <= w_beat && !w_sel_we;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = ram_rdata;
    assign busy      = (r_state == ST_GRANT) || r_rd_pend;

endmodule
`default_nettype wire
